// File: rtl/y_matrix3x3_gen.sv
// y_matrix3x3_gen: builds a 3x3 luminance window around every incoming pixel.
// Two cascaded line buffers supply the two rows above. The window registers
// themselves act as the 3-stage horizontal shift register.
// Define Y_MATRIX_BORDER_REPLICATE_EN to clamp out-of-frame taps to the
// nearest in-frame pixel. Without it, out-of-frame taps read as zero.
// Latency is 2 cycles from input pixel to window in both builds.
module y_matrix3x3_gen #(
   parameter int IMG_HDISP = 640,
   parameter int IMG_VDISP = 480
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       before_img_vsync,
   input  logic       before_img_href,
   input  logic [7:0] before_img_Y,
   output logic       after_img_vsync,
   output logic       after_img_href,
   output logic [7:0] after_img_p11,
   output logic [7:0] after_img_p12,
   output logic [7:0] after_img_p13,
   output logic [7:0] after_img_p21,
   output logic [7:0] after_img_p22,
   output logic [7:0] after_img_p23,
   output logic [7:0] after_img_p31,
   output logic [7:0] after_img_p32,
   output logic [7:0] after_img_p33
);

   localparam int CW = $clog2(IMG_HDISP + 1);
   localparam int RW = $clog2(IMG_VDISP + 1);
   localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
   localparam logic [CW-1:0] COL_LIM = CW'(IMG_HDISP);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_VDISP - 1);

   logic [7:0] lb1_mem [IMG_HDISP];
   logic [7:0] lb2_mem [IMG_HDISP];

   logic          vsync_prev_q, vsync_prev_d, href_prev_q, href_prev_d;
   logic          armed_q, armed_d;
   logic [CW-1:0] col_q, col_d, cur_col;
   logic [RW-1:0] row_q, row_d, cur_row;
   logic          vsync_rise, href_rise, href_fall, pix_in;
   logic [AW-1:0] addr;

   logic [7:0]    y_s1_q, y_s1_d, lb1_rd_q, lb1_rd_d, lb2_rd_q, lb2_rd_d;
   logic [RW-1:0] row_s1_q, row_s1_d;
   logic [CW-1:0] col_s1_q, col_s1_d;
   logic          vld_s1_q, vld_s1_d, vsync_s1_q, vsync_s1_d, href_s1_q, href_s1_d;

   logic [7:0]    tap_c3 [3];
   logic [7:0]    tap_c2 [3];
   logic [7:0]    tap_c1 [3];
   logic [7:0]    win_q [3][3];
   logic [7:0]    win_d [3][3];
   logic          vsync_s2_q, vsync_s2_d, href_s2_q, href_s2_d;

   // Edge detection, row/column tracking and the armed flag for the incoming pixel
   always_comb begin
      vsync_rise   = before_img_vsync & ~vsync_prev_q;
      href_rise    = before_img_href & ~href_prev_q;
      href_fall    = ~before_img_href & href_prev_q;
      cur_col      = href_rise ? '0 : col_q;
      cur_row      = vsync_rise ? '0 : row_q;
      pix_in       = before_img_href && (cur_col < COL_LIM);
      addr         = cur_col[AW-1:0];
      vsync_prev_d = before_img_vsync;
      href_prev_d  = before_img_href;
      armed_d      = armed_q | vsync_rise;
      col_d        = col_q;
      if (before_img_href) begin
         col_d = (cur_col == COL_LIM) ? COL_LIM : cur_col + CW'(1);
      end
      row_d = row_q;
      if (vsync_rise) begin
         row_d = '0;
      end else if (href_fall && (row_q != ROW_MAX)) begin
         row_d = row_q + RW'(1);
      end
   end

   // Stage 1 inputs: line-buffer reads of the two rows above plus the raw pixel
   always_comb begin
      lb1_rd_d   = lb1_mem[addr];
      lb2_rd_d   = lb2_mem[addr];
      y_s1_d     = before_img_Y;
      row_s1_d   = cur_row;
      col_s1_d   = cur_col;
      vld_s1_d   = pix_in & (armed_q | vsync_rise);
      vsync_s1_d = before_img_vsync;
      href_s1_d  = before_img_href;
   end

   // Line buffers: read-before-write, lb2 takes the row lb1 is about to lose
   always_ff @(posedge clk) begin
      if (pix_in) begin
         lb1_mem[addr] <= before_img_Y;
         lb2_mem[addr] <= lb1_mem[addr];
      end
   end

   // Stage 2 inputs: border handling and horizontal shift of the window
   always_comb begin
      tap_c3[2] = y_s1_q;
`ifdef Y_MATRIX_BORDER_REPLICATE_EN
      tap_c3[1] = (row_s1_q != '0) ? lb1_rd_q : y_s1_q;
      tap_c3[0] = (row_s1_q > RW'(1)) ? lb2_rd_q : tap_c3[1];
`else
      tap_c3[1] = (row_s1_q != '0) ? lb1_rd_q : 8'h00;
      tap_c3[0] = (row_s1_q > RW'(1)) ? lb2_rd_q : 8'h00;
`endif
      for (int i = 0; i < 3; i++) begin
`ifdef Y_MATRIX_BORDER_REPLICATE_EN
         tap_c2[i] = (col_s1_q != '0) ? win_q[i][2] : tap_c3[i];
         tap_c1[i] = (col_s1_q > CW'(1)) ? win_q[i][1] : tap_c2[i];
`else
         tap_c2[i] = (col_s1_q != '0) ? win_q[i][2] : 8'h00;
         tap_c1[i] = (col_s1_q > CW'(1)) ? win_q[i][1] : 8'h00;
`endif
         win_d[i][0] = vld_s1_q ? tap_c1[i] : 8'h00;
         win_d[i][1] = vld_s1_q ? tap_c2[i] : 8'h00;
         win_d[i][2] = vld_s1_q ? tap_c3[i] : 8'h00;
      end
      vsync_s2_d = vsync_s1_q;
      href_s2_d  = href_s1_q;
   end

   // Pipeline registers. Edge detectors reset high so a reset taken mid-frame
   // cannot mistake the still-high vsync for a new frame start.
   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_prev_q <= 1'b1;
         href_prev_q  <= 1'b1;
         armed_q      <= 1'b0;
         col_q        <= '0;
         row_q        <= '0;
         y_s1_q       <= '0;
         lb1_rd_q     <= '0;
         lb2_rd_q     <= '0;
         row_s1_q     <= '0;
         col_s1_q     <= '0;
         vld_s1_q     <= 1'b0;
         vsync_s1_q   <= 1'b0;
         href_s1_q    <= 1'b0;
         win_q        <= '{default: '{default: 8'h00}};
         vsync_s2_q   <= 1'b0;
         href_s2_q    <= 1'b0;
      end else begin
         vsync_prev_q <= vsync_prev_d;
         href_prev_q  <= href_prev_d;
         armed_q      <= armed_d;
         col_q        <= col_d;
         row_q        <= row_d;
         y_s1_q       <= y_s1_d;
         lb1_rd_q     <= lb1_rd_d;
         lb2_rd_q     <= lb2_rd_d;
         row_s1_q     <= row_s1_d;
         col_s1_q     <= col_s1_d;
         vld_s1_q     <= vld_s1_d;
         vsync_s1_q   <= vsync_s1_d;
         href_s1_q    <= href_s1_d;
         win_q        <= win_d;
         vsync_s2_q   <= vsync_s2_d;
         href_s2_q    <= href_s2_d;
      end
   end

   assign after_img_vsync = vsync_s2_q;
   assign after_img_href  = href_s2_q;
   assign after_img_p11   = win_q[0][0];
   assign after_img_p12   = win_q[0][1];
   assign after_img_p13   = win_q[0][2];
   assign after_img_p21   = win_q[1][0];
   assign after_img_p22   = win_q[1][1];
   assign after_img_p23   = win_q[1][2];
   assign after_img_p31   = win_q[2][0];
   assign after_img_p32   = win_q[2][1];
   assign after_img_p33   = win_q[2][2];

endmodule
